// File: rtl/dand_meas_ctrl_if.sv
// Interface: dand_meas_ctrl_if
// Purpose : Groups the host-side control/status signals and the dand chain
//           signals of the dand measurement sequencer into one bundle.
//           Signal suffixes (_i/_o) are from the sequencer's point of view.
// Signals :
//   start_i      1-cycle start pulse (host -> sequencer)
//   nsamp_log2_i log2 of launch count, latched at start
//   settle_i     settle time in cycles (0 treated as 1), latched at start
//   ffout_i      thermometer taps from the dand chain
//   out_i        dand chain end output
//   sel_o        chain launch drive
//   busy_o       measurement in progress
//   done_o       1-cycle completion pulse
//   sum_o        accumulated popcount
//   err_o        sticky error flag
// Modports: slave  = the sequencer (dand_meas_ctrl)
//           master = the host / chain side driving it
interface dand_meas_ctrl_if #(
    parameter int TAPS     = 7,
    parameter int SETTLE_W = 4
);
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int ACC_W = CNT_W + 7;

    logic                start_i;
    logic [2:0]          nsamp_log2_i;
    logic [SETTLE_W-1:0] settle_i;
    logic [TAPS-1:0]     ffout_i;
    logic                out_i;
    logic                sel_o;
    logic                busy_o;
    logic                done_o;
    logic [ACC_W-1:0]    sum_o;
    logic                err_o;

    modport slave (
        input  start_i, nsamp_log2_i, settle_i, ffout_i, out_i,
        output sel_o, busy_o, done_o, sum_o, err_o
    );

    modport master (
        output start_i, nsamp_log2_i, settle_i, ffout_i, out_i,
        input  sel_o, busy_o, done_o, sum_o, err_o
    );
endinterface

// File: rtl/dand_meas_ctrl.sv
// Module : dand_meas_ctrl
// Purpose: Sequencer for the delay-and chain measurement. Launches a rising
//          edge into the chain (sel_o), waits the settle time, captures the
//          thermometer taps, popcounts them and accumulates over
//          2^nsamp_log2 launches, then reports the sum with a done pulse.
// Ports  : clk  - system clock
//          rst  - asynchronous active-high reset
//          bus  - dand_meas_ctrl_if.slave (start/config in, chain taps in,
//                 sel/busy/done/sum/err out)
// Config : define DAND_BUBBLE_CHECK_EN to flag non-thermometer captures
//          (a 0 below a 1 in ffout_i) as errors. Undefined by default.
module dand_meas_ctrl #(
    parameter int TAPS     = 7,
    parameter int SETTLE_W = 4
) (
    input logic            clk,
    input logic            rst,
    dand_meas_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int ACC_W = CNT_W + 7;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]          state_q,  state_d;
    logic                sel_q,    sel_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;
    logic [ACC_W-1:0]    sum_q,    sum_d;
    logic [ACC_W-1:0]    acc_q,    acc_d;
    logic [6:0]          samp_q,   samp_d;
    logic [2:0]          nsamp_q,  nsamp_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] tmr_q,    tmr_d;

    logic [6:0]          lastSamp;
    logic                bubble;

    function automatic logic [CNT_W-1:0] popcount(input logic [TAPS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < TAPS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Index of the final launch: 2^n - 1 without needing an 8-bit shift.
    assign lastSamp = ~(7'h7F << nsamp_q);

`ifdef DAND_BUBBLE_CHECK_EN
    // A 1 sitting directly above a 0 marks a bubble; bit 0 is the normal
    // thermometer start and is excluded.
    logic [TAPS-1:0] edgeBits;
    assign edgeBits = bus.ffout_i & ~(bus.ffout_i << 1);
    assign bubble   = |edgeBits[TAPS-1:1];
`else
    assign bubble   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        sum_d    = sum_q;
        acc_d    = acc_q;
        samp_d   = samp_q;
        nsamp_d  = nsamp_q;
        settle_d = settle_q;
        tmr_d    = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    nsamp_d  = bus.nsamp_log2_i;
                    settle_d = (bus.settle_i == '0) ? SETTLE_W'(1) : bus.settle_i;
                    acc_d    = '0;
                    err_d    = 1'b0;
                    samp_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                sel_d   = 1'b1;
                tmr_d   = settle_q;
                state_d = S_SETTLE;
            end
            // Counter is loaded with settle>=1; leaving on the 1->0 step
            // makes the capture edge land settle+1 edges after sel rises.
            S_SETTLE: begin
                tmr_d = tmr_q - SETTLE_W'(1);
                if (tmr_q == SETTLE_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                acc_d = acc_q + ACC_W'(popcount(bus.ffout_i));
                if (!bus.out_i || bubble) begin
                    err_d = 1'b1;
                end
                sel_d   = 1'b0;
                tmr_d   = settle_q;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                tmr_d = tmr_q - SETTLE_W'(1);
                if (tmr_q == SETTLE_W'(1)) begin
                    if (bus.ffout_i != '0) begin
                        err_d = 1'b1;
                    end
                    if (samp_q == lastSamp) begin
                        sum_d   = acc_q;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        samp_d  = samp_q + 7'd1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sum_q    <= '0;
            acc_q    <= '0;
            samp_q   <= '0;
            nsamp_q  <= '0;
            settle_q <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
            samp_q   <= samp_d;
            nsamp_q  <= nsamp_d;
            settle_q <= settle_d;
            tmr_q    <= tmr_d;
        end
    end

    assign bus.sel_o  = sel_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.sum_o  = sum_q;
    assign bus.err_o  = err_q;
endmodule

// File: tb/tb_dand_meas_ctrl.sv
// Testbench: tb_dand_meas_ctrl
// Purpose  : Directed, table-driven check of dand_meas_ctrl. A tiny chain
//            model returns capVal while sel_o is high and clrVal while it is
//            low, with out_i following sel_o when outVal is set.
module tb_dand_meas_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dand_meas_ctrl_if #(.TAPS(7), .SETTLE_W(4)) bif ();

    dand_meas_ctrl #(.TAPS(7), .SETTLE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    logic [6:0] capVal = '0;
    logic [6:0] clrVal = '0;
    logic       outVal = 1'b1;

    assign bif.ffout_i = bif.sel_o ? capVal : clrVal;
    assign bif.out_i   = bif.sel_o & outVal;

    typedef struct {
        logic [2:0] n;
        logic [3:0] s;
        logic [6:0] cap;
        logic [6:0] clr;
        logic       outv;
        int         expSum;
        logic       expErr;
        int         expLaunch;
        int         expSelRun;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs[NVEC];
    int   runCycles[NVEC];

    int tests  = 0;
    int failed = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one measurement, also pulsing start_i with different config
    // mid-run, and reports the cycle at which done_o was seen.
    task automatic applyStimulus(input vec_t v, input int idx, output int doneCycle);
        int   cycles, launches, selRun, maxRun, doneCnt, busyDrop, post;
        int   sumAtDone;
        logic errAtDone, busyAfter, doneSeen, prevSel;
        string tag;
        tag = $sformatf("v%0d", idx);
        cycles = 0; launches = 0; selRun = 0; maxRun = 0; doneCnt = 0;
        busyDrop = 0; post = 0; sumAtDone = 0; errAtDone = 1'b0;
        busyAfter = 1'b1; doneSeen = 1'b0; prevSel = 1'b0; doneCycle = -1;

        @(negedge clk);
        capVal = v.cap; clrVal = v.clr; outVal = v.outv;
        bif.nsamp_log2_i = v.n; bif.settle_i = v.s; bif.start_i = 1'b1;
        @(negedge clk);
        bif.start_i = 1'b0;
        checkOutput({tag, "_busy_after_start"}, int'(bif.busy_o), 1);
        checkOutput({tag, "_err_cleared"}, int'(bif.err_o), 0);

        cycles = 1;
        while (cycles < 5000 && post < 3) begin
            if (bif.sel_o) begin
                if (!prevSel) launches++;
                selRun++;
                if (selRun > maxRun) maxRun = selRun;
            end else begin
                selRun = 0;
            end
            prevSel = bif.sel_o;
            if (doneSeen) begin
                if (post == 1) busyAfter = bif.busy_o;
                post++;
            end
            if (bif.done_o) begin
                doneCnt++;
                if (!doneSeen) begin
                    doneSeen  = 1'b1;
                    post      = 1;
                    sumAtDone = int'(bif.sum_o);
                    errAtDone = bif.err_o;
                    doneCycle = cycles;
                end
            end else if (!doneSeen && !bif.busy_o) begin
                busyDrop++;
            end
            if (cycles == 2) begin
                bif.start_i = 1'b1;
                bif.nsamp_log2_i = ~v.n;
                bif.settle_i = v.s + 4'd5;
            end else begin
                bif.start_i = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bif.start_i = 1'b0;

        if (!doneSeen) begin
            tests++; failed++;
            $display("[TB] FAIL %s_timeout: got no done_o expected done_o within 5000 cycles", tag);
        end else begin
            checkOutput({tag, "_sum"}, sumAtDone, v.expSum);
            checkOutput({tag, "_err"}, int'(errAtDone), int'(v.expErr));
            checkOutput({tag, "_launches"}, launches, v.expLaunch);
            checkOutput({tag, "_sel_run"}, maxRun, v.expSelRun);
            checkOutput({tag, "_done_pulses"}, doneCnt, 1);
            checkOutput({tag, "_busy_drops"}, busyDrop, 0);
            checkOutput({tag, "_busy_after_done"}, int'(busyAfter), 0);
            checkOutput({tag, "_sum_held"}, int'(bif.sum_o), v.expSum);
        end
    endtask

    initial begin
        int dc;
        int guard;
        logic bubbleErr;
`ifdef DAND_BUBBLE_CHECK_EN
        bubbleErr = 1'b1;
`else
        bubbleErr = 1'b0;
`endif
        //           n     s      cap         clr         out   sum  err   launch run
        vecs[0] = '{3'd0, 4'd2,  7'b0011111, 7'b0000000, 1'b1, 5,   1'b0, 1,   3};
        vecs[1] = '{3'd3, 4'd1,  7'b1111111, 7'b0000000, 1'b1, 56,  1'b0, 8,   2};
        vecs[2] = '{3'd3, 4'd0,  7'b1111111, 7'b0000000, 1'b1, 56,  1'b0, 8,   2};
        vecs[3] = '{3'd1, 4'd3,  7'b0000111, 7'b0000000, 1'b0, 6,   1'b1, 2,   4};
        vecs[4] = '{3'd2, 4'd1,  7'b0000011, 7'b0000001, 1'b1, 8,   1'b1, 4,   2};
        vecs[5] = '{3'd0, 4'd2,  7'b0010011, 7'b0000000, 1'b1, 3,   bubbleErr, 1, 3};
        vecs[6] = '{3'd7, 4'd1,  7'b0000001, 7'b0000000, 1'b1, 128, 1'b0, 128, 2};
        vecs[7] = '{3'd2, 4'd15, 7'b1111111, 7'b0000000, 1'b1, 28,  1'b0, 4,   16};
        vecs[8] = '{3'd0, 4'd1,  7'b0000000, 7'b0000000, 1'b1, 0,   1'b0, 1,   2};

        bif.start_i = 1'b0; bif.nsamp_log2_i = '0; bif.settle_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_sel", int'(bif.sel_o), 0);
        checkOutput("reset_busy", int'(bif.busy_o), 0);
        checkOutput("reset_done", int'(bif.done_o), 0);
        checkOutput("reset_sum", int'(bif.sum_o), 0);
        checkOutput("reset_err", int'(bif.err_o), 0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i, dc);
            runCycles[i] = dc;
        end

        // settle=0 must time exactly like settle=1.
        checkOutput("settle0_cycles", runCycles[2], runCycles[1]);

        // Asynchronous reset while in SETTLE.
        @(negedge clk);
        capVal = 7'h7F; clrVal = '0; outVal = 1'b1;
        bif.nsamp_log2_i = 3'd3; bif.settle_i = 4'd5; bif.start_i = 1'b1;
        @(negedge clk);
        bif.start_i = 1'b0;
        guard = 0;
        while (!bif.sel_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_test_sel_rose", int'(bif.sel_o), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_rst_sel", int'(bif.sel_o), 0);
        checkOutput("midrun_rst_busy", int'(bif.busy_o), 0);
        checkOutput("midrun_rst_sum", int'(bif.sum_o), 0);
        checkOutput("midrun_rst_err", int'(bif.err_o), 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(vecs[0], 90, dc);
        checkOutput("recovery_cycles", dc, runCycles[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
